// File: rtl/game_pkg.sv
// Shared definitions for the buzzer quiz judge: FSM state encoding,
// player ids and the default result-display hold length.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        JUDGE    = 3'd2,
        HOLD     = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    localparam logic [1:0] P1 = 2'd0;
    localparam logic [1:0] P2 = 2'd1;
    localparam logic [1:0] P3 = 2'd2;
    localparam logic [1:0] P4 = 2'd3;

    // One second at the 50 MHz board clock.
    localparam int DEFAULT_HOLD_CYCLES = 50_000_000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clr and rst both return it to zero.
module sat_counter #(
    parameter int W   = 8,
    parameter int MAX = 99
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/round_judge.sv
// Quiz round judge: arms on a target, judges the first rising buzz, holds the
// verdict, then waits for release. ROUND_JUDGE_LOCKOUT_EN adds wrong-player lockout.
module round_judge
    import game_pkg::*;
#(
    parameter int SCORE_W     = 8,
    parameter int MAX_SCORE   = 99,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 playerInputFlag,
    input  logic [1:0]           firstPlayerFlag,
    input  logic [7:0]           switchInput,
    input  logic                 allButtons,
    input  logic [7:0]           target,
    input  logic                 targetValid,
    output logic [4*SCORE_W-1:0] scores,
    output logic                 correctPulse,
    output logic                 wrongPulse,
    output logic [1:0]           lastPlayer,
    output logic                 roundActive,
    output logic                 needTarget,
    output logic [2:0]           state_dbg
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [7:0]       target_q;
    logic             prev_flag;
    logic             last_correct;
    logic [CNT_W-1:0] hold_cnt;
    logic             match;
    logic             buzz_ok;
    logic [3:0]       score_inc;
`ifdef ROUND_JUDGE_LOCKOUT_EN
    logic [3:0]       lock_mask;
`endif

    always_comb begin
        match = (target_q == switchInput);
`ifdef ROUND_JUDGE_LOCKOUT_EN
        buzz_ok = playerInputFlag && !prev_flag && !lock_mask[firstPlayerFlag];
`else
        buzz_ok = playerInputFlag && !prev_flag;
`endif
        score_inc = '0;
        if (state == JUDGE && match) begin
            score_inc[firstPlayerFlag] = 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_score
        sat_counter #(
            .W  (SCORE_W),
            .MAX(MAX_SCORE)
        ) u_score (
            .clk  (clk),
            .rst  (rst),
            .inc  (score_inc[i]),
            .clr  (allButtons),
            .count(scores[i*SCORE_W +: SCORE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            target_q     <= '0;
            prev_flag    <= 1'b0;
            last_correct <= 1'b0;
            hold_cnt     <= '0;
            correctPulse <= 1'b0;
            wrongPulse   <= 1'b0;
            lastPlayer   <= P1;
`ifdef ROUND_JUDGE_LOCKOUT_EN
            lock_mask    <= '0;
`endif
        end else begin
            prev_flag    <= playerInputFlag;
            correctPulse <= 1'b0;
            wrongPulse   <= 1'b0;
            // A game clear outranks whatever else arrives in the same cycle.
            if (allButtons) begin
                state    <= IDLE;
                hold_cnt <= '0;
`ifdef ROUND_JUDGE_LOCKOUT_EN
                lock_mask <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (targetValid) begin
                            target_q <= target;
                            state    <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (buzz_ok) begin
                            state <= JUDGE;
                        end
                    end
                    JUDGE: begin
                        lastPlayer   <= firstPlayerFlag;
                        last_correct <= match;
                        correctPulse <= match;
                        wrongPulse   <= !match;
`ifdef ROUND_JUDGE_LOCKOUT_EN
                        if (!match) begin
                            lock_mask[firstPlayerFlag] <= 1'b1;
                        end
`endif
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end
                    HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= WAIT_REL;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    WAIT_REL: begin
                        if (!playerInputFlag) begin
`ifdef ROUND_JUDGE_LOCKOUT_EN
                            if (last_correct || (&lock_mask)) begin
                                state     <= IDLE;
                                lock_mask <= '0;
                            end else begin
                                state <= ARMED;
                            end
`else
                            state <= last_correct ? IDLE : ARMED;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign roundActive = (state == ARMED) || (state == JUDGE) || (state == HOLD);
    assign needTarget  = (state == IDLE);
    assign state_dbg   = state;

endmodule
